// File: rtl/hit_resolver_if.sv
// Bus between the combat arbiter and both players / HUD.
// master = arbiter side, slave = player/gamestate side.
interface hit_resolver_if;
   logic [2:0] gamestate;
   logic [3:0] p1_state;
   logic [3:0] p2_state;
   logic [9:0] p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2;
   logic [9:0] p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2;
   logic [9:0] p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2;
   logic [9:0] p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2;
   logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
   logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
   logic [1:0] p1_hitFlag;
   logic [1:0] p2_hitFlag;
   logic [2:0] p1_health;
   logic [2:0] p2_health;
   logic [2:0] p1_block;
   logic [2:0] p2_block;
   logic [1:0] ko;

   modport master (
      input  gamestate, p1_state, p2_state,
      input  p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
      input  p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
      input  p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2,
      input  p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2,
      input  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
      input  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
      output p1_hitFlag, p2_hitFlag, p1_health, p2_health,
      output p1_block, p2_block, ko
   );

   modport slave (
      output gamestate, p1_state, p2_state,
      output p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
      output p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
      output p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2,
      output p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2,
      output p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
      output p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
      input  p1_hitFlag, p2_hitFlag, p1_health, p2_health,
      input  p1_block, p2_block, ko
   );
endinterface

// File: rtl/hit_resolver.sv
// Combat arbiter: hitbox/hurtbox overlap, one-cycle hit pulses,
// damage/block resolution, block regeneration and sticky KO.
module hit_resolver #(
   parameter int unsigned HEALTH_INIT = 5,
   parameter int unsigned BLOCK_MAX   = 3,
   parameter int unsigned DMG_BASIC   = 1,
   parameter int unsigned DMG_DIR     = 2,
   parameter int unsigned BLOCK_REGEN = 120
) (
   input  logic           clk,
   input  logic           rst,
   hit_resolver_if.master bus
);
   localparam logic [2:0]  HP_INIT    = 3'(HEALTH_INIT);
   localparam logic [2:0]  BLK_MAX    = 3'(BLOCK_MAX);
   localparam logic [2:0]  DMG_B      = 3'(DMG_BASIC);
   localparam logic [2:0]  DMG_D      = 3'(DMG_DIR);
   localparam logic [15:0] REGEN_LAST = 16'(BLOCK_REGEN - 1);
   localparam logic [2:0]  GS_MENU    = 3'd0;
   localparam logic [2:0]  GS_FIGHT   = 3'd2;
   localparam logic [3:0]  ST_BACK    = 4'd2;
   localparam logic [3:0]  ST_B_END   = 4'd4;
   localparam logic [3:0]  ST_D_END   = 4'd7;
   localparam logic [3:0]  ST_HSTUN   = 4'd9;
   localparam logic [3:0]  ST_BSTUN   = 4'd10;
   localparam logic [1:0]  HIT_NONE   = 2'b00;
   localparam logic [1:0]  HIT_BASIC  = 2'b01;
   localparam logic [1:0]  HIT_DIR    = 2'b10;

   // index 0 = p1, index 1 = p2; flag_q[i] is the hit received by player i
   logic [2:0]  health_q [2];
   logic [2:0]  health_d [2];
   logic [2:0]  block_q  [2];
   logic [2:0]  block_d  [2];
   logic [1:0]  flag_q   [2];
   logic [1:0]  flag_d   [2];
   logic [15:0] regen_q  [2];
   logic [15:0] regen_d  [2];
   logic [1:0]  used_q;
   logic [1:0]  used_d;
   logic [1:0]  ko_q;
   logic [1:0]  ko_d;

   logic [3:0]  st [2];
   logic [1:0]  det [2];
   logic [1:0]  ovl_basic;
   logic [1:0]  ovl_dir;
   logic [1:0]  blocked;

   function automatic logic overlap(
      input logic [9:0] ax1, ax2, ay1, ay2,
      input logic [9:0] bx1, bx2, by1, by2
   );
      return (ax1 <= bx2) && (bx1 <= ax2) &&
             (ay1 <= by2) && (by1 <= ay2);
   endfunction

   function automatic logic [2:0] sat_sub(
      input logic [2:0] h,
      input logic [2:0] dmg
   );
      return (h > dmg) ? h - dmg : 3'd0;
   endfunction

   always_comb begin
      st[0] = bus.p1_state;
      st[1] = bus.p2_state;
      ovl_basic[0] = overlap(
         bus.p1_basic_x1, bus.p1_basic_x2, bus.p1_basic_y1, bus.p1_basic_y2,
         bus.p2_hurt_x1, bus.p2_hurt_x2, bus.p2_hurt_y1, bus.p2_hurt_y2);
      ovl_basic[1] = overlap(
         bus.p2_basic_x1, bus.p2_basic_x2, bus.p2_basic_y1, bus.p2_basic_y2,
         bus.p1_hurt_x1, bus.p1_hurt_x2, bus.p1_hurt_y1, bus.p1_hurt_y2);
      ovl_dir[0] = overlap(
         bus.p1_dir_x1, bus.p1_dir_x2, bus.p1_dir_y1, bus.p1_dir_y2,
         bus.p2_hurt_x1, bus.p2_hurt_x2, bus.p2_hurt_y1, bus.p2_hurt_y2);
      ovl_dir[1] = overlap(
         bus.p2_dir_x1, bus.p2_dir_x2, bus.p2_dir_y1, bus.p2_dir_y2,
         bus.p1_hurt_x1, bus.p1_hurt_x2, bus.p1_hurt_y1, bus.p1_hurt_y2);
   end

   always_comb begin
      health_d = health_q;
      block_d  = block_q;
      flag_d   = flag_q;
      regen_d  = regen_q;
      used_d   = used_q;
      ko_d     = ko_q;
      blocked  = 2'b00;
      det[0]   = HIT_NONE;
      det[1]   = HIT_NONE;
      if (bus.gamestate == GS_MENU) begin
         health_d = '{HP_INIT, HP_INIT};
         block_d  = '{BLK_MAX, BLK_MAX};
         flag_d   = '{HIT_NONE, HIT_NONE};
         regen_d  = '{16'd0, 16'd0};
         used_d   = 2'b00;
         ko_d     = 2'b00;
      end else if (bus.gamestate != GS_FIGHT) begin
         flag_d = '{HIT_NONE, HIT_NONE};
      end else begin
         for (int i = 0; i < 2; i++) begin
            // a live pulse resolves on the edge that ends it
            if (flag_q[i] != HIT_NONE) begin
               flag_d[i] = HIT_NONE;
               if (st[i] == ST_BACK && block_q[i] != 3'd0) begin
                  block_d[i] = block_q[i] - 3'd1;
                  blocked[i] = 1'b1;
               end else begin
                  health_d[i] = sat_sub(health_q[i],
                     (flag_q[i] == HIT_BASIC) ? DMG_B : DMG_D);
               end
            end
            if (ko_q == 2'b00) begin
               if (blocked[i] || st[i] == ST_BSTUN) begin
                  regen_d[i] = 16'd0;
               end else if (block_q[i] < BLK_MAX) begin
                  if (regen_q[i] == REGEN_LAST) begin
                     regen_d[i] = 16'd0;
                     block_d[i] = block_q[i] + 3'd1;
                  end else begin
                     regen_d[i] = regen_q[i] + 16'd1;
                  end
               end
            end
         end
         for (int a = 0; a < 2; a++) begin
            if (st[a] == ST_B_END && ovl_basic[a]) begin
               det[a] = HIT_BASIC;
            end else if (st[a] == ST_D_END && ovl_dir[a]) begin
               det[a] = HIT_DIR;
            end
            if (st[a] != ST_B_END && st[a] != ST_D_END) begin
               used_d[a] = 1'b0;
            end else if (det[a] != HIT_NONE && !used_q[a] &&
                         ko_q == 2'b00 &&
                         flag_q[1-a] == HIT_NONE &&
                         st[1-a] != ST_HSTUN &&
                         st[1-a] != ST_BSTUN) begin
               flag_d[1-a] = det[a];
               used_d[a]   = 1'b1;
            end
         end
         ko_d = ko_q | {health_d[1] == 3'd0, health_d[0] == 3'd0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         health_q <= '{HP_INIT, HP_INIT};
         block_q  <= '{BLK_MAX, BLK_MAX};
         flag_q   <= '{HIT_NONE, HIT_NONE};
         regen_q  <= '{16'd0, 16'd0};
         used_q   <= 2'b00;
         ko_q     <= 2'b00;
      end else begin
         health_q <= health_d;
         block_q  <= block_d;
         flag_q   <= flag_d;
         regen_q  <= regen_d;
         used_q   <= used_d;
         ko_q     <= ko_d;
      end
   end

   assign bus.p1_hitFlag = flag_q[0];
   assign bus.p2_hitFlag = flag_q[1];
   assign bus.p1_health  = health_q[0];
   assign bus.p2_health  = health_q[1];
   assign bus.p1_block   = block_q[0];
   assign bus.p2_block   = block_q[1];
   assign bus.ko         = ko_q;
endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench for hit_resolver: expected hit events are queued
// with the stimulus and matched against pulses seen on the bus.
module tb_hit_resolver;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hit_resolver_if bus();
   hit_resolver dut (.clk(clk), .rst(rst), .bus(bus.master));

   typedef struct {
      int         p;
      logic [1:0] flag;
      int         cyc;
      logic [2:0] blk_pre;
      logic [2:0] hp_post;
      logic [2:0] blk_post;
      logic [1:0] ko_post;
      logic [1:0] flag_post;
   } ev_t;

   ev_t obs[$];
   ev_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   function automatic logic [2:0] hp(input int p);
      return (p == 0) ? bus.p1_health : bus.p2_health;
   endfunction
   function automatic logic [2:0] bk(input int p);
      return (p == 0) ? bus.p1_block : bus.p2_block;
   endfunction
   function automatic logic [1:0] flg(input int p);
      return (p == 0) ? bus.p1_hitFlag : bus.p2_hitFlag;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic expect_hit(input int p, input logic [1:0] f,
                             input logic [2:0] pre, input logic [2:0] h,
                             input logic [2:0] b, input logic [1:0] k);
      ev_t e;
      e.p = p; e.flag = f; e.cyc = 0; e.blk_pre = pre;
      e.hp_post = h; e.blk_post = b; e.ko_post = k; e.flag_post = 2'b00;
      exp_q.push_back(e);
   endtask

   // record every pulse plus the bus state one cycle later
   task automatic watch(input int n);
      ev_t cur [2];
      bit  open [2];
      open = '{1'b0, 1'b0};
      repeat (n) begin
         tick();
         for (int p = 0; p < 2; p++) begin
            if (open[p]) begin
               cur[p].hp_post = hp(p);
               cur[p].blk_post = bk(p);
               cur[p].ko_post = bus.ko;
               cur[p].flag_post = flg(p);
               obs.push_back(cur[p]);
               open[p] = 1'b0;
            end else if (flg(p) != 2'b00) begin
               cur[p].p = p;
               cur[p].flag = flg(p);
               cur[p].cyc = cyc;
               cur[p].blk_pre = bk(p);
               cur[p].hp_post = 'x;
               cur[p].blk_post = 'x;
               cur[p].ko_post = 'x;
               cur[p].flag_post = 'x;
               open[p] = 1'b1;
            end
         end
      end
      for (int p = 0; p < 2; p++) if (open[p]) obs.push_back(cur[p]);
   endtask

   task automatic reload();
      bus.p1_state = 4'd0;
      bus.p2_state = 4'd0;
      bus.gamestate = 3'd0;
      tick();
      bus.gamestate = 3'd2;
   endtask

   task automatic init_bus();
      bus.gamestate = 3'd2;
      bus.p1_state = 4'd0;
      bus.p2_state = 4'd0;
      bus.p1_basic_x1 = 10'd135; bus.p1_basic_x2 = 10'd213;
      bus.p1_basic_y1 = 10'd194; bus.p1_basic_y2 = 10'd227;
      bus.p1_dir_x1 = 10'd135; bus.p1_dir_x2 = 10'd230;
      bus.p1_dir_y1 = 10'd150; bus.p1_dir_y2 = 10'd180;
      bus.p1_hurt_x1 = 10'd100; bus.p1_hurt_x2 = 10'd153;
      bus.p1_hurt_y1 = 10'd170; bus.p1_hurt_y2 = 10'd320;
      bus.p2_basic_x1 = 10'd140; bus.p2_basic_x2 = 10'd200;
      bus.p2_basic_y1 = 10'd194; bus.p2_basic_y2 = 10'd227;
      bus.p2_dir_x1 = 10'd140; bus.p2_dir_x2 = 10'd210;
      bus.p2_dir_y1 = 10'd200; bus.p2_dir_y2 = 10'd230;
      bus.p2_hurt_x1 = 10'd459; bus.p2_hurt_x2 = 10'd512;
      bus.p2_hurt_y1 = 10'd170; bus.p2_hurt_y2 = 10'd320;
   endtask

   task automatic test_reset();
      logic [17:0] got;
      rst = 1'b1;
      tick();
      tick();
      got = {bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block,
             bus.p1_hitFlag, bus.p2_hitFlag, bus.ko};
      checks++;
      if (got !== {3'd5, 3'd5, 3'd3, 3'd3, 2'b00, 2'b00, 2'b00}) begin
         failures++;
         $display("FAIL reset_state got %h want %h", got,
                  {3'd5, 3'd5, 3'd3, 3'd3, 6'd0});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_hit();
      ev_t o, e;
      bus.p1_state = 4'd4;
      watch(5);
      checks++;
      if (obs.size() != 0) begin
         failures++;
         $display("FAIL no_overlap_pulses got %0d want 0", obs.size());
      end
      obs.delete();
      bus.p2_hurt_x1 = 10'd200;
      bus.p2_hurt_x2 = 10'd253;
      expect_hit(1, 2'b01, 3'd3, 3'd4, 3'd3, 2'b00);
      watch(6);
      bus.p1_state = 4'd0;
      checks++;
      if (obs.size() != exp_q.size()) begin
         failures++;
         $display("FAIL basic_count got %0d want %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         o = obs.pop_front(); e = exp_q.pop_front(); checks++;
         if (o.p !== e.p || o.flag !== e.flag || o.blk_pre !== e.blk_pre ||
             o.hp_post !== e.hp_post || o.blk_post !== e.blk_post ||
             o.ko_post !== e.ko_post || o.flag_post !== e.flag_post) begin
            failures++;
            $display("FAIL basic_ev got p%0d f%b pre%0d hp%0d blk%0d ko%b fp%b want p%0d f%b pre%0d hp%0d blk%0d ko%b fp%b",
               o.p, o.flag, o.blk_pre, o.hp_post, o.blk_post, o.ko_post, o.flag_post,
               e.p, e.flag, e.blk_pre, e.hp_post, e.blk_post, e.ko_post, e.flag_post);
         end
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_single_land();
      ev_t o, e;
      reload();
      bus.p1_state = 4'd4;
      expect_hit(1, 2'b01, 3'd3, 3'd4, 3'd3, 2'b00);
      watch(20);
      bus.p1_state = 4'd5;
      tick();
      bus.p1_state = 4'd4;
      expect_hit(1, 2'b01, 3'd3, 3'd3, 3'd3, 2'b00);
      watch(5);
      bus.p1_state = 4'd0;
      checks++;
      if (obs.size() != exp_q.size()) begin
         failures++;
         $display("FAIL once_count got %0d want %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         o = obs.pop_front(); e = exp_q.pop_front(); checks++;
         if (o.p !== e.p || o.flag !== e.flag || o.blk_pre !== e.blk_pre ||
             o.hp_post !== e.hp_post || o.blk_post !== e.blk_post ||
             o.ko_post !== e.ko_post || o.flag_post !== e.flag_post) begin
            failures++;
            $display("FAIL once_ev got p%0d f%b hp%0d blk%0d fp%b want p%0d f%b hp%0d blk%0d fp%b",
               o.p, o.flag, o.hp_post, o.blk_post, o.flag_post,
               e.p, e.flag, e.hp_post, e.blk_post, e.flag_post);
         end
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_block();
      ev_t o, e;
      reload();
      bus.p2_state = 4'd2;
      for (int k = 0; k < 4; k++) begin
         bus.p1_state = 4'd7;
         if (k < 3) expect_hit(1, 2'b10, 3'(3 - k), 3'd5, 3'(2 - k), 2'b00);
         else       expect_hit(1, 2'b10, 3'd0, 3'd3, 3'd0, 2'b00);
         watch(4);
         bus.p1_state = 4'd0;
         tick();
      end
      bus.p2_state = 4'd0;
      checks++;
      if (obs.size() != exp_q.size()) begin
         failures++;
         $display("FAIL block_count got %0d want %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         o = obs.pop_front(); e = exp_q.pop_front(); checks++;
         if (o.p !== e.p || o.flag !== e.flag || o.blk_pre !== e.blk_pre ||
             o.hp_post !== e.hp_post || o.blk_post !== e.blk_post ||
             o.ko_post !== e.ko_post || o.flag_post !== e.flag_post) begin
            failures++;
            $display("FAIL block_ev got f%b pre%0d hp%0d blk%0d fp%b want f%b pre%0d hp%0d blk%0d fp%b",
               o.flag, o.blk_pre, o.hp_post, o.blk_post, o.flag_post,
               e.flag, e.blk_pre, e.hp_post, e.blk_post, e.flag_post);
         end
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_trade();
      ev_t o, e;
      reload();
      bus.p1_state = 4'd4;
      bus.p2_state = 4'd7;
      expect_hit(0, 2'b10, 3'd3, 3'd3, 3'd3, 2'b00);
      expect_hit(1, 2'b01, 3'd3, 3'd4, 3'd3, 2'b00);
      watch(4);
      bus.p1_state = 4'd0;
      bus.p2_state = 4'd0;
      checks++;
      if (obs.size() != 2 || obs[0].cyc !== obs[1].cyc) begin
         failures++;
         $display("FAIL trade_same_cycle got %0d events want 2 in one cycle",
                  obs.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         o = obs.pop_front(); e = exp_q.pop_front(); checks++;
         if (o.p !== e.p || o.flag !== e.flag || o.blk_pre !== e.blk_pre ||
             o.hp_post !== e.hp_post || o.blk_post !== e.blk_post ||
             o.ko_post !== e.ko_post || o.flag_post !== e.flag_post) begin
            failures++;
            $display("FAIL trade_ev got p%0d f%b hp%0d want p%0d f%b hp%0d",
               o.p, o.flag, o.hp_post, e.p, e.flag, e.hp_post);
         end
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_regen();
      int n;
      reload();
      bus.p2_state = 4'd2;
      bus.p1_state = 4'd7;
      tick();
      tick();
      bus.p1_state = 4'd0;
      bus.p2_state = 4'd0;
      checks++;
      if (bus.p2_block !== 3'd2) begin
         failures++;
         $display("FAIL regen_setup got %0d want 2", bus.p2_block);
      end
      n = -1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (bus.p2_block == 3'd3) begin
            n = c;
            break;
         end
      end
      checks++;
      if (n != 120) begin
         failures++;
         $display("FAIL regen_cycles got %0d want 120", n);
      end
      repeat (10) tick();
      checks++;
      if (bus.p2_block !== 3'd3) begin
         failures++;
         $display("FAIL regen_sat got %0d want 3", bus.p2_block);
      end
      reload();
      bus.p2_state = 4'd2;
      bus.p1_state = 4'd7;
      tick();
      tick();
      bus.p1_state = 4'd0;
      bus.p2_state = 4'd10;
      repeat (200) tick();
      checks++;
      if (bus.p2_block !== 3'd2) begin
         failures++;
         $display("FAIL regen_stun got %0d want 2", bus.p2_block);
      end
      bus.p2_state = 4'd0;
   endtask

   task automatic test_ko();
      ev_t o, e;
      logic [13:0] got;
      reload();
      for (int k = 0; k < 5; k++) begin
         bus.p1_state = 4'd4;
         expect_hit(1, 2'b01, 3'd3, 3'(4 - k), 3'd3,
                    (k == 4) ? 2'b10 : 2'b00);
         watch(3);
         bus.p1_state = 4'd0;
         tick();
      end
      checks++;
      if (bus.ko !== 2'b10) begin
         failures++;
         $display("FAIL ko_bits got %b want 10", bus.ko);
      end
      bus.p1_state = 4'd4;
      watch(6);
      bus.p1_state = 4'd0;
      checks++;
      if (obs.size() != exp_q.size()) begin
         failures++;
         $display("FAIL ko_count got %0d want %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         o = obs.pop_front(); e = exp_q.pop_front(); checks++;
         if (o.p !== e.p || o.flag !== e.flag || o.hp_post !== e.hp_post ||
             o.ko_post !== e.ko_post || o.flag_post !== e.flag_post) begin
            failures++;
            $display("FAIL ko_ev got p%0d f%b hp%0d ko%b fp%b want p%0d f%b hp%0d ko%b fp%b",
               o.p, o.flag, o.hp_post, o.ko_post, o.flag_post,
               e.p, e.flag, e.hp_post, e.ko_post, e.flag_post);
         end
      end
      obs.delete(); exp_q.delete();
      bus.gamestate = 3'd0;
      tick();
      got = {bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block, bus.ko};
      checks++;
      if (got !== {3'd5, 3'd5, 3'd3, 3'd3, 2'b00}) begin
         failures++;
         $display("FAIL ko_reload got %h want %h", got,
                  {3'd5, 3'd5, 3'd3, 3'd3, 2'b00});
      end
      bus.gamestate = 3'd2;
   endtask

   task automatic test_freeze_reset();
      logic [17:0] got;
      reload();
      bus.p1_state = 4'd4;
      tick();
      checks++;
      if (bus.p2_hitFlag !== 2'b01) begin
         failures++;
         $display("FAIL freeze_pulse got %b want 01", bus.p2_hitFlag);
      end
      bus.gamestate = 3'd1;
      tick();
      checks++;
      if ({bus.p2_hitFlag, bus.p2_health} !== {2'b00, 3'd5}) begin
         failures++;
         $display("FAIL freeze_cancel got f%b hp%0d want f00 hp5",
                  bus.p2_hitFlag, bus.p2_health);
      end
      bus.gamestate = 3'd2;
      tick();
      tick();
      checks++;
      if ({bus.p2_hitFlag, bus.p2_health} !== {2'b00, 3'd5}) begin
         failures++;
         $display("FAIL freeze_used got f%b hp%0d want f00 hp5",
                  bus.p2_hitFlag, bus.p2_health);
      end
      bus.p1_state = 4'd0;
      tick();
      bus.p1_state = 4'd4;
      tick();
      rst = 1'b1;
      bus.p1_state = 4'd0;
      tick();
      got = {bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block,
             bus.p1_hitFlag, bus.p2_hitFlag, bus.ko};
      checks++;
      if (got !== {3'd5, 3'd5, 3'd3, 3'd3, 2'b00, 2'b00, 2'b00}) begin
         failures++;
         $display("FAIL rst_mid_pulse got %h want %h", got,
                  {3'd5, 3'd5, 3'd3, 3'd3, 6'd0});
      end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      init_bus();
      test_reset();
      test_basic_hit();
      test_single_land();
      test_block();
      test_trade();
      test_regen();
      test_ko();
      test_freeze_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hit_resolver.md
Name: hit_resolver

Overview:
- Combat arbiter between the two player FSMs. It is the producer side of their hitFlag/health/block interface.
- Each cycle it compares each attacker's active hitbox against the opponent's main hurtbox.
- It issues one-cycle hitFlag pulses, applies damage or block cost, regenerates block meter, and flags KO.
- Sits at top level beside both player instances; all outputs feed the players and the HUD/gamestate logic.

Parameters:
HEALTH_INIT, 5, health loaded on reset / gamestate 0 (3-bit)
BLOCK_MAX, 3, block meter full value and saturation ceiling (3-bit)
DMG_BASIC, 1, health lost per unblocked basic hit
DMG_DIR, 2, health lost per unblocked directional hit
BLOCK_REGEN, 120, cycles between +1 block regeneration (16-bit counter)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
gamestate  input  3  0=reset/menu (reload), 2=fight (active), others=frozen
p1_state, p2_state  input  4 each  player current_state (IDLE=0 … B_ATTACK_END=4, D_ATTACK_END=7, MOVEBACKWARDS=2, HITSTUN=9, BLOCKSTUN=10)
p1_basic_{x1,x2,y1,y2}, p2_basic_{x1,x2,y1,y2}  input  10 each  basic-attack hitbox
p1_dir_{x1,x2,y1,y2}, p2_dir_{x1,x2,y1,y2}  input  10 each  directional-attack hitbox
p1_hurt_{x1,x2,y1,y2}, p2_hurt_{x1,x2,y1,y2}  input  10 each  main hurtbox
p1_hitFlag, p2_hitFlag  output  2 each  00 none, 01 hitByBasic, 10 hitByDirectional; flag is for the player receiving the hit
p1_health, p2_health  output  3 each  remaining health
p1_block, p2_block  output  3 each  block meter
ko  output  2  bit0 = p1 health 0, bit1 = p2 health 0; sticky

Behaviour:
- Reset (rst=1) or gamestate==0:
  - health=HEALTH_INIT, block=BLOCK_MAX
  - hitFlags=00, ko=00
  - regen counters=0, hit_used flags=0, pending=0
- Overlap test is inclusive: ax1<=bx2 && bx1<=ax2 && ay1<=by2 && by1<=ay2.
- Attack detection, for attacker A vs defender D, only when gamestate==2:
  - A in state 4: use A's basic box. A in state 7: use A's dir box.
  - Conditions for a hit: overlap with D's hurtbox, A.hit_used==0, D not in 9/10, D.hitFlag currently 00, ko==00.
- Cycle timing:
  - Detection in cycle k → at edge k+1: D.hitFlag <= type, A.hit_used <= 1, pending type latched.
  - At edge k+2: D.hitFlag <= 00 (exactly one-cycle pulse) and the outcome is resolved.
    - Blocked if D.state==2 and D.block>0: D.block -= 1, health unchanged.
    - Otherwise: D.health -= DMG, saturating at 0.
  - The block value presented during the pulse cycle is the pre-hit value. This matches the player's block>0 decision.
- hit_used clears whenever A's state is neither 4 nor 7. Each attack therefore lands at most once.
- Trades: both directions are evaluated independently in the same cycle. Both players may receive pulses and damage simultaneously.
- Block regen, per player, gamestate==2 only:
  - Counter increments each cycle while block<BLOCK_MAX and state!=10.
  - At BLOCK_REGEN-1 the counter wraps to 0 and block += 1.
  - Counter resets to 0 on any blocked hit or while in state 10.
- KO:
  - ko bit set at the edge that health becomes 0.
  - Once any ko bit is set, detection is disabled; values hold until gamestate 0 or rst.
  - A trade that kills both players sets ko=11.
- gamestate not 0/2:
  - hitFlags forced 00 and pending cleared (a pulse in flight is cancelled without damage).
  - All other registers hold.
- rst mid-pulse: next cycle shows full reset values, with no damage applied.

Test Plan:
1. P1 state 4, P1 basic box (135,194)-(213,227) overlaps P2 hurtbox (459,170)-(512,320)? No → hitFlag stays 00. Move P2 hurtbox to (200,170)-(253,320) → p2_hitFlag=01 for exactly 1 cycle; p2_health 5→4 on the next edge.
2. Same overlap held 20 cycles in state 4 → only one pulse and health drops by 1 only. P1 goes to 5 then back to 4 → second pulse allowed.
3. P2 state 2 with block=3, hit by P1 directional (state 7) → p2_hitFlag=10; p2_block 3→2, p2_health unchanged. Repeat with block=0 → health 5→3.
4. Simultaneous P1 state 4 and P2 state 7, each overlapping the other's hurtbox → both pulse in the same cycle; p1_health 5→3, p2_health 5→4.
5. Block=2, no stun, BLOCK_REGEN=120 → block=3 after 120 cycles, then holds at 3. Repeat while in state 10 → no regen.
6. p2_health=1, basic hit → health 0, ko=10; further overlaps produce no pulses. gamestate=0 → health 5, block 3, ko 00.
